// File: rtl/nes_joypad_pkg.sv
// Shared constants and helpers for the NES joypad serialiser: button bit
// positions, Four Score signature bytes and sequence lengths.
package nes_joypad_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_U      = 4;
  localparam int BTN_D      = 5;
  localparam int BTN_L      = 6;
  localparam int BTN_R      = 7;

  localparam logic [7:0] SIG0 = 8'b0000_1000;
  localparam logic [7:0] SIG1 = 8'b0000_0100;

  localparam int SEQ_NORMAL    = 8;
  localparam int SEQ_FOURSCORE = 24;

  typedef enum logic {
    MODE_NORMAL    = 1'b0,
    MODE_FOURSCORE = 1'b1
  } seq_mode_e;

  function automatic logic [4:0] seq_limit(input seq_mode_e mode);
    return (mode == MODE_FOURSCORE) ? 5'(SEQ_FOURSCORE) : 5'(SEQ_NORMAL);
  endfunction

  // Turbo only ever adds presses on A/B; it never masks a real press.
  function automatic logic [7:0] merge_btn(input logic [7:0] pad,
                                           input logic [7:0] loader,
                                           input logic [1:0] turbo,
                                           input logic       phase);
    logic [7:0] m;
    m        = pad | loader;
    m[BTN_A] = m[BTN_A] | (turbo[0] & phase);
    m[BTN_B] = m[BTN_B] | (turbo[1] & phase);
    return m;
  endfunction

endpackage

// File: rtl/nes_joypad_mux_if.sv
// Bundle of NES-core joypad signals and button sources seen by the serialiser.
interface nes_joypad_mux_if #(
  parameter int NUM_PADS = 2
);
  logic                    strobe;
  logic [1:0]              joy_clock;
  logic [8*NUM_PADS-1:0]   pad_btn;
  logic [8*NUM_PADS-1:0]   loader_btn;
  logic [2*NUM_PADS-1:0]   turbo_req;
  logic                    fourscore_en;
  logic [1:0]              joy_data;

  modport master (
    output strobe, joy_clock, pad_btn, loader_btn, turbo_req, fourscore_en,
    input  joy_data
  );

  modport slave (
    input  strobe, joy_clock, pad_btn, loader_btn, turbo_req, fourscore_en,
    output joy_data
  );
endinterface

// File: rtl/joypad_shift_port.sv
// One $4016/$4017 data line: 24-bit shift register with bit counter, falling
// edge detect on the port clock, and open-bus 1 once the sequence is spent.
module joypad_shift_port
  import nes_joypad_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_strobe,
  input  logic        i_joy_clock,
  input  seq_mode_e   i_mode,
  input  logic [23:0] i_load,
  output logic        o_data
);

  logic [23:0] r_sr;
  logic [4:0]  r_cnt;
  seq_mode_e   r_mode;
  logic        r_jc_q;

  logic        w_fall;
  logic [4:0]  w_limit;

  assign w_fall  = r_jc_q & ~i_joy_clock;
  assign w_limit = seq_limit(r_mode);

  // Reset value of the edge register is 1 so a clock held high by the core
  // through reset never produces a spurious shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_mode <= MODE_NORMAL;
      r_jc_q <= 1'b1;
    end else begin
      r_jc_q <= i_joy_clock;
      if (i_strobe) begin
        r_sr   <= i_load;
        r_cnt  <= '0;
        r_mode <= i_mode;
      end else if (w_fall) begin
        r_sr <= {1'b0, r_sr[23:1]};
        if (r_cnt != w_limit)
          r_cnt <= r_cnt + 5'd1;
      end
    end
  end

  assign o_data = (r_cnt == w_limit) ? 1'b1 : r_sr[0];

endmodule

// File: rtl/nes_joypad_mux.sv
// Joypad serialiser top: merges pad/loader/turbo buttons, runs the shared
// turbo timer and feeds the two independent shift ports.
module nes_joypad_mux
  import nes_joypad_pkg::*;
#(
  parameter int NUM_PADS = 2,
  parameter int FREQ     = 37_800_000,
  parameter int TURBO_HZ = 15
) (
  input  logic             clk,
  input  logic             reset,
  nes_joypad_mux_if.slave  bus
);

  localparam int TURBO_DIV = FREQ / (2 * TURBO_HZ);
  localparam int TURBO_W   = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
  localparam logic [TURBO_W-1:0] TURBO_RELOAD = TURBO_W'(TURBO_DIV - 1);

  logic [TURBO_W-1:0] r_turbo_cnt;
  logic               r_turbo_phase;

  logic [7:0]  w_btn [4];
  logic [23:0] w_load [2];
  logic [1:0]  w_data;
  seq_mode_e   w_mode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_turbo_cnt   <= '0;
      r_turbo_phase <= 1'b0;
    end else if (r_turbo_cnt == '0) begin
      r_turbo_cnt   <= TURBO_RELOAD;
      r_turbo_phase <= ~r_turbo_phase;
    end else begin
      r_turbo_cnt <= r_turbo_cnt - 1'b1;
    end
  end

  // Absent pads (2/3 on a two-pad build) read as all buttons released.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      if (gi < NUM_PADS) begin : g_present
        assign w_btn[gi] = merge_btn(bus.pad_btn[8*gi +: 8],
                                     bus.loader_btn[8*gi +: 8],
                                     bus.turbo_req[2*gi +: 2],
                                     r_turbo_phase);
      end else begin : g_absent
        assign w_btn[gi] = 8'h00;
      end
    end
  endgenerate

  assign w_mode = (bus.fourscore_en && (NUM_PADS == 4)) ? MODE_FOURSCORE : MODE_NORMAL;

  assign w_load[0] = (w_mode == MODE_FOURSCORE) ? {SIG0, w_btn[2], w_btn[0]}
                                                : {16'h0000, w_btn[0]};
  assign w_load[1] = (w_mode == MODE_FOURSCORE) ? {SIG1, w_btn[3], w_btn[1]}
                                                : {16'h0000, w_btn[1]};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      joypad_shift_port u_port (
        .clk         (clk),
        .reset       (reset),
        .i_strobe    (bus.strobe),
        .i_joy_clock (bus.joy_clock[gi]),
        .i_mode      (w_mode),
        .i_load      (w_load[gi]),
        .o_data      (w_data[gi])
      );
    end
  endgenerate

  assign bus.joy_data = w_data;

endmodule
